// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax arbiter slice.
//   state_t           : arbiter FSM state encoding
//   MAX_SIZE_DEFAULT  : default largest legal vector length
//   TIMEOUT_DEFAULT   : default cycles allowed between sm_start and sm_done
//   ERR_NONE/ERR_FAULT: values carried on rsp_error
//   size_legal()      : job size check (non-zero and not above the buffer depth)
package softmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int unsigned MAX_SIZE_DEFAULT = 256;
  localparam int unsigned TIMEOUT_DEFAULT  = 4096;

  localparam logic ERR_NONE  = 1'b0;
  localparam logic ERR_FAULT = 1'b1;

  function automatic logic size_legal(input logic [31:0] size,
                                      input int unsigned max_size);
    return (size != '0) && (size <= max_size);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection (purely combinational).
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  IDW      index with highest priority this cycle
//   grant     out NUM_REQ  one-hot winner, all-zero when no request
//   grant_idx out IDW      encoded winner index (0 when no request)
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic           found;
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // Walk upward from rr_ptr with wrap; the first asserted request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ)) begin
        sum = sum - (IDW+1)'(NUM_REQ);
      end
      cand = sum[IDW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/softmax_arbiter.sv
// Shares one softmax_unit between NUM_REQ requesters, one job at a time.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid / req_ready    : per-requester job handshake (req_ready one-hot)
//   req_in_ptr/out_ptr/size  : packed job fields, requester g at [32g+31:32g]
//   rsp_valid / rsp_ready    : response handshake
//   rsp_id/result/error      : response payload
//   sm_start, sm_*_ptr, sm_size : softmax_unit command
//   sm_ready, sm_done, sm_result: softmax_unit status
//   busy                     : high whenever the FSM is not idle
module softmax_arbiter
  import softmax_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 4,
  parameter  int unsigned MAX_SIZE = MAX_SIZE_DEFAULT,
  parameter  int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
  localparam int unsigned IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_in_ptr,
  input  logic [NUM_REQ*32-1:0] req_out_ptr,
  input  logic [NUM_REQ*32-1:0] req_size,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_error,
  output logic                  sm_start,
  output logic [31:0]           sm_input_ptr,
  output logic [31:0]           sm_output_ptr,
  output logic [31:0]           sm_size,
  input  logic                  sm_ready,
  input  logic                  sm_done,
  input  logic [31:0]           sm_result,
  output logic                  busy
);

  state_t               state, state_nx;
  logic [IDW-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       gidx;
  logic [31:0]          sel_in, sel_out, sel_size;
  logic [31:0]          tmo_cnt;
  logic                 accept;
  logic                 rsp_load;
  logic                 rsp_err_nx;
  logic [31:0]          rsp_res_nx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // One-hot grant lets the field mux be a plain OR of the selected slices.
  always_comb begin
    sel_in   = '0;
    sel_out  = '0;
    sel_size = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_in   = sel_in   | req_in_ptr [i*32 +: 32];
        sel_out  = sel_out  | req_out_ptr[i*32 +: 32];
        sel_size = sel_size | req_size   [i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    sm_start   = 1'b0;
    accept     = 1'b0;
    rsp_load   = 1'b0;
    rsp_err_nx = ERR_NONE;
    rsp_res_nx = '0;
    case (state)
      ST_IDLE: begin
        // Gated with rst so req_ready is low while reset is held.
        if (!rst) begin
          req_ready = grant;
        end
        if (!rst && (|grant)) begin
          accept = 1'b1;
          if (size_legal(sel_size, MAX_SIZE)) begin
            state_nx = ST_LAUNCH;
          end else begin
            rsp_load   = 1'b1;
            rsp_err_nx = ERR_FAULT;
            rsp_res_nx = '0;
            state_nx   = ST_RESP;
          end
        end
      end
      ST_LAUNCH: begin
        if (sm_ready) begin
          sm_start = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // sm_done is tested first so it beats a coincident timeout.
        if (sm_done) begin
          rsp_load   = 1'b1;
          rsp_err_nx = ERR_NONE;
          rsp_res_nx = sm_result;
          state_nx   = ST_RESP;
        end else if (tmo_cnt == 32'(TIMEOUT - 1)) begin
          rsp_load   = 1'b1;
          rsp_err_nx = ERR_FAULT;
          rsp_res_nx = '0;
          state_nx   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    rsp_valid = (state == ST_RESP);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      tmo_cnt       <= '0;
      sm_input_ptr  <= '0;
      sm_output_ptr <= '0;
      sm_size       <= '0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_error     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sm_input_ptr  <= sel_in;
        sm_output_ptr <= sel_out;
        sm_size       <= sel_size;
        rsp_id        <= gidx;
        rr_ptr        <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + IDW'(1);
      end
      if (rsp_load) begin
        rsp_result <= rsp_res_nx;
        rsp_error  <= rsp_err_nx;
      end
      // Counter is cleared while launching so the first WAIT cycle sees 0.
      if (state == ST_LAUNCH) begin
        tmo_cnt <= '0;
      end else if (state == ST_WAIT) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end

endmodule
